led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencer for a running-light LED bank built around a prescale tick counter.
//   Owns the tick counter, runs an IDLE/RUN/PAUSE FSM and rotates a one-hot LED
//   pattern on every tick. Sits between board-level button/command logic and the LED pins.
// PARAMETERS
//   CNT_MAX  25'd24999999  reset value of the tick period register (cycles per step, minus 1)
//   LED_NUM  4             number of LED outputs (2..16)
// PORTS
//   sys_clk     in   1        system clock
//   sys_rst     in   1        synchronous reset, active-high
//   start       in   1        1-cycle request: IDLE -> RUN
//   stop        in   1        1-cycle request: any state -> IDLE
//   pause       in   1        level; high holds sequence while in RUN/PAUSE
//   dir         in   1        0 = rotate toward MSB, 1 = rotate toward LSB
//   period_val  in   25       new tick period (cycles per step, minus 1)
//   period_wr   in   1        load strobe for period_val
//   led_out     out  LED_NUM  one-hot LED pattern, registered
//   step_tick   out  1        1-cycle pulse on every LED step
//   wrap_pulse  out  1        1-cycle pulse when pattern wraps (or bounces)
//   busy        out  1        high in RUN or PAUSE
// BEHAVIOUR
//   Reset (sync, sys_rst=1): state IDLE, cnt=0, period_reg=CNT_MAX, led_out=0,
//     step_tick=0, wrap_pulse=0, busy=0. Reset overrides every other input.
//   Priority each cycle: sys_rst > stop > start > pause > counting.
//   IDLE: cnt=0, led_out=0. period_wr loads period_reg; period_val<1 is clamped to 1.
//     period_wr outside IDLE is ignored. start -> RUN next edge: led_out=1 (bit0), cnt=0.
//   RUN: cnt increments each cycle; when cnt==period_reg -> cnt=0, and on the same edge
//     led_out steps and step_tick=1 for that one cycle. One step = period_reg+1 cycles.
//     dir is sampled on the stepping edge. dir=0: bit i -> i+1; bit LED_NUM-1 -> bit0.
//     dir=1: bit i -> i-1; bit0 -> bit LED_NUM-1.
//     wrap_pulse=1 coincident with step_tick on every wrap step.
//     pause=1 -> PAUSE next edge; cnt and led_out frozen.
//   PAUSE: cnt, led_out held; no ticks. pause=0 -> RUN; counting resumes from held cnt.
//   stop in RUN/PAUSE: IDLE next edge, led_out=0, cnt=0, no step_tick.
//   start while busy: ignored. start and stop together: stop wins.
//   busy = (state != IDLE), registered with state.
//   led_out is always one-hot in RUN/PAUSE and all-zero in IDLE.
//   Tick counter is 25 bits, compared with ==, never exceeds period_reg.
// CONFIGURATION
//   LED_SEQ_BOUNCE_EN defined: ping-pong mode. An internal direction register replaces
//     dir; it resets to 0 and is cleared to 0 on start. At an end bit the step reverses
//     instead of wrapping: MSB -> LSB-side neighbour, bit0 -> bit1. wrap_pulse fires on
//     each reversal step. The dir input is unused.
//   Not defined: rotate/wrap mode as above; dir input is honoured.
// TESTING
//   (LED_NUM=4, period_wr with period_val=3 in IDLE, so one step = 4 cycles)
//   1 reset mid-RUN -> next edge led_out=0, busy=0, period_reg=CNT_MAX.
//   2 start, dir=0 -> led_out 0001,0010,0100,1000,0001 at 4-cycle spacing;
//     step_tick on each step; wrap_pulse only on the 1000->0001 step.
//   3 dir=1 while running from 0100 -> next steps 0010,0001,1000; wrap on 0001->1000.
//   4 pause=1 for 10 cycles mid-step -> led_out/cnt frozen, no pulses; after release
//     the remaining cycles of the step complete exactly.
//   5 start+stop same cycle in RUN -> IDLE, led_out=0. period_wr while in RUN -> ignored.
//     period_val=0 in IDLE -> period_reg=1, one step = 2 cycles.
//   6 LED_SEQ_BOUNCE_EN -> 0001,0010,0100,1000,0100,0010,0001,0010;
//     wrap_pulse on the 1000->0100 and 0001->0010 steps.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: running-light LED sequencer.
// A prescale tick counter drives an IDLE/RUN/PAUSE FSM that steps a one-hot
// LED pattern once every (period_reg + 1) cycles while running.
// Optional feature macro: LED_SEQ_BOUNCE_EN selects ping-pong mode. In that
// mode the pattern reverses at either end bit and the dir input is unused.
// Without the macro the pattern rotates and wraps, and dir sets the direction.
module led_seq_ctrl #(
    parameter logic [24:0] CNT_MAX = 25'd24999999,
    parameter int          LED_NUM = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               dir,
    input  logic [24:0]        period_val,
    input  logic               period_wr,
    output logic [LED_NUM-1:0] led_out,
    output logic               step_tick,
    output logic               wrap_pulse,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             state_r;
    logic [24:0]        cnt_r;
    logic [24:0]        period_r;
    logic [LED_NUM-1:0] led_r;
    logic               step_tick_r;
    logic               wrap_pulse_r;
    logic               busy_r;

    logic [LED_NUM-1:0] next_led_s;
    logic               next_wrap_s;
    logic               count_en_s;
    logic               step_s;

    // Rotate the pattern one place toward the MSB, MSB wraps into bit 0.
    function automatic logic [LED_NUM-1:0] rot_up(input logic [LED_NUM-1:0] v);
        return {v[LED_NUM-2:0], v[LED_NUM-1]};
    endfunction

    // Rotate the pattern one place toward the LSB, bit 0 wraps into the MSB.
    function automatic logic [LED_NUM-1:0] rot_down(input logic [LED_NUM-1:0] v);
        return {v[0], v[LED_NUM-1:1]};
    endfunction

    // Shift without wrap, used when bouncing off an end bit.
    function automatic logic [LED_NUM-1:0] shift_up(input logic [LED_NUM-1:0] v);
        return {v[LED_NUM-2:0], 1'b0};
    endfunction

    function automatic logic [LED_NUM-1:0] shift_down(input logic [LED_NUM-1:0] v);
        return {1'b0, v[LED_NUM-1:1]};
    endfunction

`ifdef LED_SEQ_BOUNCE_EN
    logic bdir_r;
    logic next_bdir_s;
    logic unused_dir_s;

    assign unused_dir_s = dir;

    // Ping-pong next pattern: reverse direction instead of wrapping at an end bit.
    always_comb begin
        next_led_s  = led_r;
        next_wrap_s = 1'b0;
        next_bdir_s = bdir_r;
        if (bdir_r == 1'b0) begin
            if (led_r[LED_NUM-1] == 1'b1) begin
                next_led_s  = shift_down(led_r);
                next_wrap_s = 1'b1;
                next_bdir_s = 1'b1;
            end else begin
                next_led_s  = shift_up(led_r);
            end
        end else begin
            if (led_r[0] == 1'b1) begin
                next_led_s  = shift_up(led_r);
                next_wrap_s = 1'b1;
                next_bdir_s = 1'b0;
            end else begin
                next_led_s  = shift_down(led_r);
            end
        end
    end

    // Bounce direction: cleared on reset and on a fresh start, updated on each step.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bdir_r <= 1'b0;
        end else if (state_r == ST_IDLE && start && !stop) begin
            bdir_r <= 1'b0;
        end else if (step_s) begin
            bdir_r <= next_bdir_s;
        end else begin
            bdir_r <= bdir_r;
        end
    end
`else
    // Rotate/wrap next pattern: dir picks the rotation, wrap flags the end-bit crossing.
    always_comb begin
        next_led_s  = led_r;
        next_wrap_s = 1'b0;
        if (dir == 1'b0) begin
            next_led_s  = rot_up(led_r);
            next_wrap_s = led_r[LED_NUM-1];
        end else begin
            next_led_s  = rot_down(led_r);
            next_wrap_s = led_r[0];
        end
    end
`endif

    // Counting is enabled in RUN, and in PAUSE on the cycle pause drops, so a
    // pause delays the pending step by exactly the number of paused cycles.
    always_comb begin
        count_en_s = 1'b0;
        if (stop) begin
            count_en_s = 1'b0;
        end else if (state_r != ST_IDLE && !pause) begin
            count_en_s = 1'b1;
        end else begin
            count_en_s = 1'b0;
        end
    end

    assign step_s = count_en_s && (cnt_r == period_r);

    // Main FSM with tick counter, period register and all registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 25'd0;
            period_r     <= CNT_MAX;
            led_r        <= '0;
            step_tick_r  <= 1'b0;
            wrap_pulse_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            step_tick_r  <= 1'b0;
            wrap_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 25'd0;
                    if (period_wr) begin
                        period_r <= (period_val == 25'd0) ? 25'd1 : period_val;
                    end else begin
                        period_r <= period_r;
                    end
                    if (stop) begin
                        state_r <= ST_IDLE;
                        led_r   <= '0;
                        busy_r  <= 1'b0;
                    end else if (start) begin
                        state_r <= ST_RUN;
                        led_r   <= {{(LED_NUM-1){1'b0}}, 1'b1};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        led_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 25'd0;
                        led_r   <= '0;
                        busy_r  <= 1'b0;
                    end else if (pause) begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        if (step_s) begin
                            cnt_r        <= 25'd0;
                            led_r        <= next_led_s;
                            step_tick_r  <= 1'b1;
                            wrap_pulse_r <= next_wrap_s;
                        end else begin
                            cnt_r <= cnt_r + 25'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 25'd0;
                    led_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out    = led_r;
    assign step_tick  = step_tick_r;
    assign wrap_pulse = wrap_pulse_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl (LED_NUM=4).
// Build with LED_SEQ_BOUNCE_EN defined to exercise ping-pong mode.
module tb_led_seq_ctrl;

    localparam logic [24:0] CNT_MAX = 25'd24999999;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        dir = 1'b0;
    logic [24:0] period_val = 25'd0;
    logic        period_wr = 1'b0;
    logic [3:0]  led_out;
    logic        step_tick;
    logic        wrap_pulse;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    led_seq_ctrl #(.CNT_MAX(CNT_MAX), .LED_NUM(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .dir        (dir),
        .period_val (period_val),
        .period_wr  (period_wr),
        .led_out    (led_out),
        .step_tick  (step_tick),
        .wrap_pulse (wrap_pulse),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        cyc(); cyc();
        total_cnt++; if ({led_out, busy, step_tick, wrap_pulse} !== 7'b0) $display("FAIL reset_outs got led=%b busy=%b tick=%b wrap=%b want all 0", led_out, busy, step_tick, wrap_pulse); else pass_cnt++;
        total_cnt++; if (dut.period_r !== CNT_MAX) $display("FAIL reset_period got %0d want %0d", dut.period_r, CNT_MAX); else pass_cnt++;
        sys_rst = 1'b0;
    endtask

    task automatic test_period_load(input logic [24:0] val, input logic [24:0] want);
        period_val = val; period_wr = 1'b1;
        cyc();
        period_wr = 1'b0;
        total_cnt++; if (dut.period_r !== want) $display("FAIL period_load got %0d want %0d", dut.period_r, want); else pass_cnt++;
    endtask

    task automatic test_rotate_fwd();
        logic [3:0] seq [4];
        logic       wr  [4];
        logic [3:0] cur;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wr  = '{1'b0, 1'b0, 1'b0, 1'b1};
        dir = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++; if (led_out !== 4'b0001 || busy !== 1'b1) $display("FAIL fwd_start got led=%b busy=%b want 0001 1", led_out, busy); else pass_cnt++;
        cur = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c == 4) cur = seq[s];
                total_cnt++;
                if (led_out !== cur || step_tick !== (c == 4) || wrap_pulse !== (c == 4 && wr[s]))
                    $display("FAIL fwd_step%0d_c%0d got led=%b tick=%b wrap=%b want led=%b tick=%b wrap=%b",
                             s, c, led_out, step_tick, wrap_pulse, cur, (c == 4), (c == 4 && wr[s]));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_rotate_rev();
        logic [3:0] seq [5];
        logic       dr  [5];
        logic       wr  [5];
        logic [3:0] cur;
        seq = '{4'b0010, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        dr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cur = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            dir = dr[s];
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c == 4) cur = seq[s];
                total_cnt++;
                if (led_out !== cur || step_tick !== (c == 4) || wrap_pulse !== (c == 4 && wr[s]))
                    $display("FAIL rev_step%0d_c%0d got led=%b tick=%b wrap=%b want led=%b tick=%b wrap=%b",
                             s, c, led_out, step_tick, wrap_pulse, cur, (c == 4), (c == 4 && wr[s]));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_pause();
        // From 1000 with dir=1: two cycles in, then hold for 10 cycles.
        cyc(); cyc();
        total_cnt++; if (dut.cnt_r !== 25'd2) $display("FAIL pause_pre_cnt got %0d want 2", dut.cnt_r); else pass_cnt++;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total_cnt++;
            if (led_out !== 4'b1000 || dut.cnt_r !== 25'd2 || step_tick !== 1'b0 || wrap_pulse !== 1'b0 || busy !== 1'b1)
                $display("FAIL pause_hold%0d got led=%b cnt=%0d tick=%b wrap=%b busy=%b want 1000 2 0 0 1",
                         i, led_out, dut.cnt_r, step_tick, wrap_pulse, busy);
            else pass_cnt++;
        end
        pause = 1'b0;
        cyc();
        total_cnt++; if (led_out !== 4'b1000 || step_tick !== 1'b0) $display("FAIL pause_resume1 got led=%b tick=%b want 1000 0", led_out, step_tick); else pass_cnt++;
        cyc();
        total_cnt++; if (led_out !== 4'b0100 || step_tick !== 1'b1 || wrap_pulse !== 1'b0) $display("FAIL pause_resume2 got led=%b tick=%b wrap=%b want 0100 1 0", led_out, step_tick, wrap_pulse); else pass_cnt++;
    endtask

    task automatic test_stop_start();
        dir = 1'b0;
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        total_cnt++; if (led_out !== 4'b0000 || busy !== 1'b0 || step_tick !== 1'b0) $display("FAIL startstop got led=%b busy=%b tick=%b want 0000 0 0", led_out, busy, step_tick); else pass_cnt++;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++; if (led_out !== 4'b0001 || busy !== 1'b1) $display("FAIL restart got led=%b busy=%b want 0001 1", led_out, busy); else pass_cnt++;
        period_val = 25'd0; period_wr = 1'b1;
        cyc();
        period_wr = 1'b0;
        total_cnt++; if (dut.period_r !== 25'd3) $display("FAIL wr_in_run got %0d want 3", dut.period_r); else pass_cnt++;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++; if (led_out !== 4'b0001 || busy !== 1'b1 || step_tick !== 1'b0) $display("FAIL start_busy got led=%b busy=%b tick=%b want 0001 1 0", led_out, busy, step_tick); else pass_cnt++;
        cyc(); cyc();
        total_cnt++; if (led_out !== 4'b0010 || step_tick !== 1'b1) $display("FAIL start_busy_step got led=%b tick=%b want 0010 1", led_out, step_tick); else pass_cnt++;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        total_cnt++; if (led_out !== 4'b0000 || busy !== 1'b0 || step_tick !== 1'b0) $display("FAIL stop_run got led=%b busy=%b tick=%b want 0000 0 0", led_out, busy, step_tick); else pass_cnt++;
        test_period_load(25'd0, 25'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        total_cnt++; if (led_out !== 4'b0001 || step_tick !== 1'b0) $display("FAIL p1_c1 got led=%b tick=%b want 0001 0", led_out, step_tick); else pass_cnt++;
        cyc();
        total_cnt++; if (led_out !== 4'b0010 || step_tick !== 1'b1) $display("FAIL p1_c2 got led=%b tick=%b want 0010 1", led_out, step_tick); else pass_cnt++;
        cyc(); cyc();
        total_cnt++; if (led_out !== 4'b0100 || step_tick !== 1'b1) $display("FAIL p1_c4 got led=%b tick=%b want 0100 1", led_out, step_tick); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        // Still running at period 1; reset also beats a concurrent start.
        cyc();
        sys_rst = 1'b1; start = 1'b1;
        cyc();
        sys_rst = 1'b0; start = 1'b0;
        total_cnt++; if (led_out !== 4'b0000 || busy !== 1'b0 || step_tick !== 1'b0) $display("FAIL rst_run got led=%b busy=%b tick=%b want 0000 0 0", led_out, busy, step_tick); else pass_cnt++;
        total_cnt++; if (dut.period_r !== CNT_MAX) $display("FAIL rst_run_period got %0d want %0d", dut.period_r, CNT_MAX); else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [3:0] seq [7];
        logic       wr  [7];
        logic [3:0] cur;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dir = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        total_cnt++; if (led_out !== 4'b0001) $display("FAIL bnc_start got %b want 0001", led_out); else pass_cnt++;
        cur = 4'b0001;
        for (int s = 0; s < 7; s++) begin
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if (c == 4) cur = seq[s];
                total_cnt++;
                if (led_out !== cur || step_tick !== (c == 4) || wrap_pulse !== (c == 4 && wr[s]))
                    $display("FAIL bnc_step%0d_c%0d got led=%b tick=%b wrap=%b want led=%b tick=%b wrap=%b",
                             s, c, led_out, step_tick, wrap_pulse, cur, (c == 4), (c == 4 && wr[s]));
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_period_load(25'd3, 25'd3);
`ifndef LED_SEQ_BOUNCE_EN
        test_rotate_fwd();
        test_rotate_rev();
        test_pause();
`endif
        test_stop_start();
        test_reset_mid_run();
`ifdef LED_SEQ_BOUNCE_EN
        test_period_load(25'd3, 25'd3);
        test_bounce();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
